hazard_ctrl: RTL

Parametrised hazard-detection and stall controller for the 5-stage pipeline, sitting between the ID stage and the PC/IF-ID/ID-EX control mux. It detects load-use hazards and, optionally, hazards against branches resolved in ID. It holds the pipeline for a configurable number of cycles using an internal stall counter, and flushes IF/ID on taken branches. A saturating stall-event counter is exposed for performance debug.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_match.sv | 21 ++
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller:
// controller state encoding, default register-address width and the
// instruction field positions of the rs/rt source operands.
package hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hz_state_e;

  localparam int REG_AW_DEF = 5;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

endpackage

// File: rtl/hazard_match.sv
// Combinational operand comparator: flags when a producer's destination
// register is a live source operand (rs or rt) of the instruction in ID.
// Register 0 is hard-wired to zero and never creates a dependency.
module hazard_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] r_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              uses_rs_i,
  input  logic              uses_rt_i,
  output logic              hit_o
);

  // Hit only for a non-zero destination matching an operand ID really reads.
  always_comb begin
    hit_o = (r_i != '0) &&
            ((uses_rs_i && (r_i == rs_i)) || (uses_rt_i && (r_i == rt_i)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard-detection and stall controller for the 5-stage pipeline.
// Decides in IDLE how many cycles the instruction in ID must wait,
// holds PC and IF/ID while inserting bubbles into ID/EX for that many
// cycles, flushes IF/ID on a taken branch resolved in ID, and keeps a
// saturating count of stall episodes for performance debug.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int LOAD_STALLS  = 1,
  parameter int BRANCH_IN_ID = 1,
  parameter int EVT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic              id_is_branch_i,
  input  logic              branch_taken_i,
  input  logic              idex_memread_i,
  input  logic              idex_regwrite_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              exmem_memread_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              bubble_o,
  output logic              ifid_flush_o,
  output logic              stall_o,
  output logic [EVT_W-1:0]  stall_evt_o
);

  // Wide enough for the longest episode (LOAD_STALLS + 1 on a branch).
  localparam int CNT_W = $clog2(LOAD_STALLS + 2);

  localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(LOAD_STALLS);
  localparam logic [CNT_W-1:0] S_BRLD = CNT_W'(LOAD_STALLS + 1);
  localparam logic [CNT_W-1:0] S_ONE  = CNT_W'(1);
  localparam logic             BR_EN  = (BRANCH_IN_ID != 0);

  if ((LOAD_STALLS < 1) || (LOAD_STALLS > 7)) begin : g_bad_load_stalls
    $error("hazard_ctrl: LOAD_STALLS must be in 1..7");
  end

  hz_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EVT_W-1:0]  evt_q;

  logic [REG_AW-1:0] id_rs, id_rt;
  logic              hit_idex, hit_exmem;
  logic [CNT_W-1:0]  s_req;
  logic              stall_req;
  logic              start_ep;
  logic              unused_instr;

  assign id_rs        = instr_i[RS_LSB +: REG_AW];
  assign id_rt        = instr_i[RT_LSB +: REG_AW];
  assign unused_instr = ^{instr_i[31:RS_MSB+1], instr_i[RT_LSB-1:0]};

  hazard_match #(.REG_AW(REG_AW)) u_match_idex (
    .r_i       (idex_rd_i),
    .rs_i      (id_rs),
    .rt_i      (id_rt),
    .uses_rs_i (id_uses_rs_i),
    .uses_rt_i (id_uses_rt_i),
    .hit_o     (hit_idex)
  );

  hazard_match #(.REG_AW(REG_AW)) u_match_exmem (
    .r_i       (exmem_rd_i),
    .rs_i      (id_rs),
    .rt_i      (id_rt),
    .uses_rs_i (id_uses_rs_i),
    .uses_rt_i (id_uses_rt_i),
    .hit_o     (hit_exmem)
  );

  // Required stall length; a branch compared in ID needs its operands one
  // stage earlier than an ALU consumer, so it waits longer behind a load
  // and also waits behind an ALU result still in EX or a load in MEM.
  always_comb begin
    s_req = '0;
    if (BR_EN && id_is_branch_i) begin
      if (idex_memread_i && hit_idex) begin
        s_req = S_BRLD;
      end else if (idex_regwrite_i && hit_idex) begin
        s_req = S_ONE;
      end else if (exmem_memread_i && hit_exmem) begin
        s_req = S_ONE;
      end
    end else if (idex_memread_i && hit_idex) begin
      s_req = S_LOAD;
    end
  end

  assign stall_req = (state_q == HOLD) ? 1'b1 : (s_req != '0);
  assign start_ep  = (state_q == IDLE) && (s_req != '0);

  // State and remaining-hold-cycle register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: multi-cycle episodes park in HOLD until the count runs out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s_req > S_ONE) begin
          state_d = HOLD;
          cnt_d   = s_req - S_ONE;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - S_ONE;
        if (cnt_q == S_ONE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pipeline control outputs; reset holds the pipe frozen with a bubble.
  always_comb begin
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    bubble_o     = 1'b0;
    ifid_flush_o = 1'b0;
    stall_o      = 1'b0;
    if (rst_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      bubble_o     = 1'b1;
    end else if (stall_req) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      bubble_o     = 1'b1;
      stall_o      = 1'b1;
    end else begin
      ifid_flush_o = BR_EN && id_is_branch_i && branch_taken_i;
    end
  end

  // Episode counter: one count per IDLE-to-stall decision, sticks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_q <= '0;
    end else if (start_ep && (evt_q != '1)) begin
      evt_q <= evt_q + EVT_W'(1);
    end
  end

  assign stall_evt_o = evt_q;

endmodule
